mult_table_sweeper: RTL and testbench
=====================================

Name: mult_table_sweeper

Overview:
Operand sequencer and self-checker placed directly upstream of the times-table multiplier memory.
- On `start`, drives every (a, b) pair 0..7 x 0..7 into the multiplier, one pair per cycle.
- Samples the multiplier's `result` after a fixed read latency and compares it against a locally computed product.
- Reports a pass/fail summary.
- Serves as the built-in self-test and bring-up driver for the multiplier.

Parameters:
- OP_W, 3, operand width; sweep covers 0..2^OP_W-1 on each operand.
- RES_W, 5, width of the multiplier result bus.
- LAT, 1, multiplier read latency in cycles (legal 1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin sweep; sampled only in IDLE.
- a  output  OP_W  operand a to multiplier.
- b  output  OP_W  operand b to multiplier.
- result  input  RES_W  multiplier output.
- busy  output  1  high while issuing or draining.
- done  output  1  single-cycle pulse at sweep end.
- pass  output  1  high if last completed sweep had zero mismatches.
- err_count  output  2*OP_W+1  mismatches in last/current sweep.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0.
  - delay pipeline valid bits cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 at an edge -> ISSUE.
  - err_count cleared and pass cleared at the same edge.
  - a=0, b=0 driven in the first ISSUE cycle (cycle 0).
- ISSUE:
  - One pair per cycle; b is the inner loop (a,b) = (0,0),(0,1)..(0,7),(1,0)..(7,7).
  - Each issued pair pushes {valid=1, expected=(a*b) mod 2^RES_W} into a LAT+1 deep delay line.
  - After pair 63 (cycle 63) -> DRAIN.
  - a/b hold (7,7) through DRAIN.
- Compare timing:
  - The pair driven in cycle i has its result sampled at the edge ending cycle i+LAT.
  - At that edge, if result != expected, err_count increments.
- Width rule: expected is truncated to RES_W bits (7*7=49 -> 17 for RES_W=5); a matching truncated value is a pass.
- DRAIN:
  - Lasts LAT cycles (cycles 64..63+LAT); busy=1.
  - Then -> DONE.
- DONE:
  - Lasts one cycle (cycle 64+LAT): done=1, busy=0.
  - pass=(err_count==0), registered and held.
  - -> IDLE.
- Counter range: err_count max 64 fits 2*OP_W+1 bits; no saturation needed.
- err_count and pass remain stable in IDLE until the next accepted start.
- start while busy or in DONE is ignored; it does not restart or extend the sweep.
- Reset mid-sweep:
  - Returns to IDLE next edge.
  - In-flight compares are discarded; counters zeroed.
  - No done pulse.
- busy=1 exactly in cycles 0..63+LAT; total sweep 65+LAT cycles from the start edge.

Optional Feature:
- Macro: SWEEP_FIRST_ERR_EN.
- When defined, adds outputs:
  - first_err_a [OP_W]
  - first_err_b [OP_W]
  - first_err_res [RES_W]
  - first_err_vld [1]
- Capture rule:
  - On the first mismatch of a sweep, captures that pair's operands and observed result; first_err_vld=1.
  - Later mismatches do not overwrite.
  - All four are cleared at reset and at start acceptance.
  - Operands travel in the delay line alongside expected.
- When undefined: these ports and the operand fields of the delay line do not exist.

Test Plan:
1. Ideal multiplier model, LAT=1, start pulse -> 64 distinct pairs in b-inner order; done pulse in cycle 65; pass=1, err_count=0.
2. Model returns 0 for (3,5) -> err_count=1, pass=0; with SWEEP_FIRST_ERR_EN: first_err_a=3, first_err_b=5, first_err_res=0, first_err_vld=1.
3. Model returns truncated (7*7)%32=17 for (7,7); second run returns 49%64=49 on a 6-bit-truncated bus to RES_W=5 -> first run pass=1; forcing 18 gives err_count=1.
4. Model wrong on all pairs -> err_count=64, no wrap, pass=0.
5. start held high throughout sweep, then again in DONE cycle -> only one sweep; second start is accepted only if high in an IDLE cycle.
6. rst_n=0 at cycle 20 of ISSUE -> next cycle busy=0, err_count=0, no done; fresh start completes normally. LAT=3 build -> done in cycle 67.

Source files
------------

// File: rtl/mult_table_sweeper.sv
// Purpose: times-table self-test driver; sweeps every (a,b) operand pair into the multiplier and checks each result.
// Latency: one pair per cycle from the cycle after start; done pulses 64+LAT cycles after the start edge.
// Backpressure: none; start is only honoured in IDLE. Optional first-mismatch capture port set: SWEEP_FIRST_ERR_EN.
module mult_table_sweeper #(
    parameter int OP_W  = 3,
    parameter int RES_W = 5,
    parameter int LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    input  logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2*OP_W:0]   err_count
`ifdef SWEEP_FIRST_ERR_EN
    ,
    output logic [OP_W-1:0]   first_err_a,
    output logic [OP_W-1:0]   first_err_b,
    output logic [RES_W-1:0]  first_err_res,
    output logic              first_err_vld
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    // Flat pair index: a is the upper half, b the lower half, so b is the inner loop.
    logic [2*OP_W-1:0] idx;
    logic [1:0]        drain_cnt;

    // Delay line: entry k holds the pair issued k+1 cycles ago. The pair being
    // driven this cycle is the extra (combinational) stage in front of it.
    logic [LAT-1:0]    dl_vld;
    logic [RES_W-1:0]  dl_exp [LAT];
`ifdef SWEEP_FIRST_ERR_EN
    logic [OP_W-1:0]   dl_a   [LAT];
    logic [OP_W-1:0]   dl_b   [LAT];
`endif

    logic [2*OP_W-1:0] prod;
    logic [RES_W-1:0]  exp_cur;
    logic              accept;
    logic              last_pair;
    logic              drain_end;
    logic              mismatch;
    logic [2*OP_W:0]   err_nxt;

    assign a         = idx[2*OP_W-1:OP_W];
    assign b         = idx[OP_W-1:0];
    assign prod      = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    assign exp_cur   = RES_W'(prod);
    assign accept    = (state == S_IDLE) && start;
    assign last_pair = (idx == '1);
    assign drain_end = (drain_cnt == 2'(LAT - 1));
    assign mismatch  = dl_vld[LAT-1] && (result != dl_exp[LAT-1]);
    assign err_nxt   = err_count + {{(2*OP_W){1'b0}}, mismatch};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: begin
                busy = 1'b1;
                if (last_pair) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand index, drain timer, mismatch counter and pass flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            drain_cnt <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (accept) idx <= '0;
            else if (state == S_ISSUE && !last_pair) idx <= idx + 1'b1;

            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : 2'd0;

            // The final compare lands on the edge entering DONE, so pass uses err_nxt.
            if (accept) begin
                err_count <= '0;
                pass      <= 1'b0;
            end else begin
                err_count <= err_nxt;
                if (state == S_DRAIN && drain_end) pass <= (err_nxt == '0);
            end
        end
    end

    // Expected-result delay line, aligned to the multiplier read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_vld <= '0;
            for (int k = 0; k < LAT; k++) dl_exp[k] <= '0;
        end else begin
            dl_vld[0] <= (state == S_ISSUE);
            dl_exp[0] <= exp_cur;
            for (int k = 1; k < LAT; k++) begin
                dl_vld[k] <= dl_vld[k-1];
                dl_exp[k] <= dl_exp[k-1];
            end
        end
    end

`ifdef SWEEP_FIRST_ERR_EN
    // Operands ride alongside the expected value so the failing pair can be reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                dl_a[k] <= '0;
                dl_b[k] <= '0;
            end
        end else begin
            dl_a[0] <= a;
            dl_b[0] <= b;
            for (int k = 1; k < LAT; k++) begin
                dl_a[k] <= dl_a[k-1];
                dl_b[k] <= dl_b[k-1];
            end
        end
    end

    // Latch the first mismatch of a sweep; later ones never overwrite it.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_res <= '0;
            first_err_vld <= 1'b0;
        end else if (mismatch && !first_err_vld) begin
            first_err_a   <= dl_a[LAT-1];
            first_err_b   <= dl_b[LAT-1];
            first_err_res <= result;
            first_err_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_table_sweeper.sv
module tb_mult_table_sweeper;
    localparam int OP_W  = 3;
    localparam int RES_W = 5;
    localparam int LAT   = 1;
    localparam int NV    = 1 << OP_W;
    localparam int NP    = NV * NV;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [OP_W-1:0]   a, b;
    logic [RES_W-1:0]  result;
    logic              busy, done, pass;
    logic [2*OP_W:0]   err_count;
`ifdef SWEEP_FIRST_ERR_EN
    logic [OP_W-1:0]   first_err_a, first_err_b;
    logic [RES_W-1:0]  first_err_res;
    logic              first_err_vld;
`endif

    int n_chk = 0;
    int n_err = 0;

    mult_table_sweeper #(.OP_W(OP_W), .RES_W(RES_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .result(result),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef SWEEP_FIRST_ERR_EN
        , .first_err_a(first_err_a), .first_err_b(first_err_b),
        .first_err_res(first_err_res), .first_err_vld(first_err_vld)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: registered read with LAT cycles of latency and injectable faults.
    int           mode = 0;
    logic [63:0]  mask = '0;
    logic [OP_W-1:0] ah [LAT];
    logic [OP_W-1:0] bh [LAT];

    always @(posedge clk) begin
        ah[0] <= a;
        bh[0] <= b;
        for (int k = 1; k < LAT; k++) begin
            ah[k] <= ah[k-1];
            bh[k] <= bh[k-1];
        end
    end

    function automatic logic [RES_W-1:0] mult_model(int m, logic [63:0] msk, int x, int y);
        int p;
        p = (x * y) % (1 << RES_W);
        case (m)
            1: if (x == 3 && y == 5) p = 0;
            2: if (x == 7 && y == 7) p = 18;
            3: p = (p + 1) % (1 << RES_W);
            4: if (msk[x*NV + y]) p = p ^ 1;
            default: ;
        endcase
        return RES_W'(p);
    endfunction

    assign result = mult_model(mode, mask, int'(ah[LAT-1]), int'(bh[LAT-1]));

    // Reference: walk the whole table with plain arithmetic.
    function automatic int ref_errs(int m, logic [63:0] msk);
        int n = 0;
        for (int x = 0; x < NV; x++)
            for (int y = 0; y < NV; y++)
                if (int'(mult_model(m, msk, x, y)) != (x * y) % (1 << RES_W)) n++;
        return n;
    endfunction

    function automatic int ref_first(int m, logic [63:0] msk);
        for (int x = 0; x < NV; x++)
            for (int y = 0; y < NV; y++)
                if (int'(mult_model(m, msk, x, y)) != (x * y) % (1 << RES_W))
                    return (x << 16) | (y << 8) | int'(mult_model(m, msk, x, y));
        return -1;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_sweep(string nm, int m, logic [63:0] msk, int exp_err,
                             int exp_first, bit hold);
        int c, done_at, order_bad, busy_bad;
        mode = m;
        mask = msk;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);                 // cycle 0
        if (!hold) start = 1'b0;
        c = 0; done_at = -1; order_bad = 0; busy_bad = 0;
        while (c < 200 && done_at < 0) begin
            if (c < NP && (int'(a) != c / NV || int'(b) != c % NV)) order_bad++;
            if (busy != (c <= NP - 1 + LAT)) busy_bad++;
            if (done) done_at = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check({nm, ".order"}, order_bad, 0);
        check({nm, ".busy"}, busy_bad, 0);
        check({nm, ".done_cycle"}, done_at, NP + LAT);
        check({nm, ".err_count"}, int'(err_count), exp_err);
        check({nm, ".pass"}, int'(pass), int'(exp_err == 0));
`ifdef SWEEP_FIRST_ERR_EN
        check({nm, ".first_vld"}, int'(first_err_vld), int'(exp_first >= 0));
        if (exp_first >= 0)
            check({nm, ".first_pair"},
                  (int'(first_err_a) << 16) | (int'(first_err_b) << 8) | int'(first_err_res),
                  exp_first);
`endif
        @(negedge clk);                 // first IDLE cycle
        start = 1'b0;
        check({nm, ".done_pulse"}, int'(done), 0);
        repeat (4) @(negedge clk);
        check({nm, ".idle_busy"}, int'(busy), 0);
        check({nm, ".err_hold"}, int'(err_count), exp_err);
        check({nm, ".pass_hold"}, int'(pass), int'(exp_err == 0));
    endtask

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_first;   // {a,b,res} packed as a<<16|b<<8|res, -1 when none
        bit    hold;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   c, seen_done, seen_busy;
        logic [63:0] rm;

        tbl[0] = '{"ideal",     0, 0,  -1,                       1'b0};
        tbl[1] = '{"bad_3x5",   1, 1,  (3 << 16) | (5 << 8) | 0,  1'b0};
        tbl[2] = '{"force18",   2, 1,  (7 << 16) | (7 << 8) | 18, 1'b0};
        tbl[3] = '{"all_wrong", 3, 64, (0 << 16) | (0 << 8) | 1,  1'b0};
        tbl[4] = '{"hold_start",0, 0,  -1,                       1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.a", int'(a), 0);
        check("rst.b", int'(b), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.pass", int'(pass), 0);
        check("rst.err_count", int'(err_count), 0);
`ifdef SWEEP_FIRST_ERR_EN
        check("rst.first_vld", int'(first_err_vld), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_sweep(tbl[i].name, tbl[i].mode, 64'd0, tbl[i].exp_err, tbl[i].exp_first, tbl[i].hold);

        // After the held-start sweep no second sweep may have begun.
        seen_busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) seen_busy++;
        end
        check("hold_start.no_restart", seen_busy, 0);

        // Randomised fault masks checked against the table-walking reference.
        for (int r = 0; r < 4; r++) begin
            if (r == 0) rm = 64'd1 << $urandom_range(63);
            else        rm = {$urandom, $urandom} & {$urandom, $urandom};
            run_sweep($sformatf("rand%0d", r), 4, rm, ref_errs(4, rm), ref_first(4, rm), 1'b0);
        end

        // Reset in the middle of ISSUE, with errors already accumulated.
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);     // cycle 20
        check("midrst.busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.busy", int'(busy), 0);
        check("midrst.err_count", int'(err_count), 0);
        check("midrst.a", int'(a), 0);
        rst_n = 1'b1;
        seen_done = 0;
        c = 0;
        while (c < 80) begin
            @(negedge clk);
            if (done || busy) seen_done++;
            c++;
        end
        check("midrst.no_done", seen_done, 0);

        run_sweep("after_rst", 0, 64'd0, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
